// File: rtl/multi_edge_detect.sv
// Multi-channel input conditioner: synchroniser, stable-count debounce and
// mode-selectable edge pulse per channel. Define EDGE_STICKY_EN for sticky event flags.
module multi_edge_detect #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     s,
    input  logic [2*N-1:0]   mode,
`ifdef EDGE_STICKY_EN
    input  logic [N-1:0]     clr,
    output logic [N-1:0]     flag,
`endif
    output logic [N-1:0]     y,
    output logic [N-1:0]     level,
    output logic             any_edge
);

    localparam int            CW       = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q [N];
    logic [N-1:0]           sync_out;
    logic [CW-1:0]          cnt_q  [N];
    logic [CW-1:0]          cnt_d  [N];
    logic [N-1:0]           level_q, level_d;
    logic [N-1:0]           prev_q;
    logic [N-1:0]           y_q, y_d;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            sync_out[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // The count only runs while the synchronised input disagrees with the accepted level,
    // so any disagreement shorter than DB_CYCLES is dropped.
    always_comb begin
        level_d = level_q;
        y_d     = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_out[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = sync_out[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
            y_d[i] = (mode[2*i]   &  level_q[i] & ~prev_q[i])
                   | (mode[2*i+1] & ~level_q[i] &  prev_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            level_q <= '0;
            prev_q  <= '0;
            y_q     <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], s[i]};
                cnt_q[i]  <= cnt_d[i];
            end
            level_q <= level_d;
            prev_q  <= level_q;
            y_q     <= y_d;
        end
    end

`ifdef EDGE_STICKY_EN
    logic [N-1:0] flag_q, flag_d;

    // A new pulse takes priority over a simultaneous clear.
    always_comb begin
        flag_d = y_q | (flag_q & ~clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag = flag_q;
`endif

    assign y        = y_q;
    assign level    = level_q;
    assign any_edge = |y_q;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Scoreboard bench for multi_edge_detect (N=4, SYNC_STAGES=2, DB_CYCLES=4).
module tb_multi_edge_detect;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   s;
    logic [2*N-1:0] mode;
    logic [N-1:0]   y;
    logic [N-1:0]   level;
    logic           any_edge;
`ifdef EDGE_STICKY_EN
    logic [N-1:0]   clr;
    logic [N-1:0]   flag;
`endif

    int checks   = 0;
    int failures = 0;
    int ecnt     = 0;

    typedef struct {
        int           at;
        logic [N-1:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    multi_edge_detect #(
        .N(4),
        .SYNC_STAGES(2),
        .DB_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s(s),
        .mode(mode),
`ifdef EDGE_STICKY_EN
        .clr(clr),
        .flag(flag),
`endif
        .y(y),
        .level(level),
        .any_edge(any_edge)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, ecnt, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int at, input logic [N-1:0] v);
        exp_t e;
        e.at  = at;
        e.val = v;
        sb.push_back(e);
    endtask

    // Monitor: every nonzero y must match the next queued pulse, at the queued edge.
    always @(negedge clk) begin
        if (y !== '0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse at edge %0d: got y=%0h expected none", ecnt, y);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_edge", ecnt, mon_e.at);
                check("pulse_val", 32'(y), 32'(mon_e.val));
                check("any_edge_hi", 32'(any_edge), 32'd1);
            end
        end else if (any_edge !== 1'b0) begin
            check("any_edge_idle", 32'(any_edge), 32'd0);
        end
    end

    initial begin
        int k;
        rst  = 1'b1;
        s    = '0;
        mode = '0;
`ifdef EDGE_STICKY_EN
        clr  = '0;
`endif
        step(2);
        check("rst_y", 32'(y), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_any", 32'(any_edge), 32'd0);
`ifdef EDGE_STICKY_EN
        check("rst_flag", 32'(flag), 32'd0);
`endif

        // Single rising edge on ch0, all channels in rising mode
        mode = 8'h55;
        rst  = 1'b0;
        s    = 4'b0001;
        k    = ecnt;
        expect_pulse(k + 7, 4'b0001);
        step(5);
        check("t1_level_e5", 32'(level), 32'd0);
        step(1);
        check("t1_level_e6", 32'(level), 32'b0001);
        step(8);

        // 3-cycle glitch on ch1 (both-edge mode) must be filtered
        mode = 8'h5D;
        s    = 4'b0011;
        step(3);
        s    = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t2_glitch_level", 32'(level), 32'b0001);
        end

        // ch2 falling mode: no pulse on rise, one pulse after the fall
        mode = 8'h6D;
        s    = 4'b0101;
        step(6);
        check("t3_level_hi", 32'(level), 32'b0101);
        step(4);
        s    = 4'b0001;
        k    = ecnt;
        expect_pulse(k + 7, 4'b0100);
        step(6);
        check("t3_level_lo", 32'(level), 32'b0001);
        step(6);

        // ch3 mode off: level tracks, no pulses; mode switch on steady input is silent
        mode = 8'h2D;
        s    = 4'b1001;
        step(6);
        check("t4_level_hi", 32'(level), 32'b1001);
        step(2);
        s    = 4'b0001;
        step(6);
        check("t4_level_lo", 32'(level), 32'b0001);
        step(2);
        mode = 8'hED;
        step(10);
        check("t4_level_hold", 32'(level), 32'b0001);

        // Reset two cycles into a ch0 debounce count
        s = 4'b0000;
        step(4);
        rst = 1'b1;
        step(1);
        check("t5_rst_y", 32'(y), 32'd0);
        check("t5_rst_level", 32'(level), 32'd0);
        check("t5_rst_any", 32'(any_edge), 32'd0);
        rst = 1'b0;
        s   = 4'b0001;
        k   = ecnt;
        expect_pulse(k + 7, 4'b0001);
        step(5);
        check("t5_level_e5", 32'(level), 32'd0);
        step(1);
        check("t5_level_e6", 32'(level), 32'b0001);
        step(8);

        // Simultaneous edges on all channels, both-edge mode
        mode = 8'hFF;
        s    = 4'b1110;
        k    = ecnt;
        expect_pulse(k + 7, 4'b1111);
        step(6);
        check("t6_level", 32'(level), 32'b1110);
        step(8);

`ifdef EDGE_STICKY_EN
        // Sticky flag: set, isolated clear, set-vs-clear collision, clear again
        mode = 8'h03;
        s    = 4'b1111;
        k    = ecnt;
        expect_pulse(k + 7, 4'b0001);
        step(8);
        check("st_flag_set", 32'(flag), 32'b0001);
        clr = 4'b0001;
        step(1);
        clr = 4'b0000;
        check("st_flag_clr1", 32'(flag), 32'd0);
        s = 4'b1110;
        k = ecnt;
        expect_pulse(k + 7, 4'b0001);
        step(7);
        clr = 4'b0001;
        step(1);
        clr = 4'b0000;
        check("st_flag_collide", 32'(flag), 32'b0001);
        step(2);
        clr = 4'b0001;
        step(1);
        clr = 4'b0000;
        check("st_flag_clr2", 32'(flag), 32'd0);
        step(2);
`endif

        step(3);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
